uart_frame_rx: RTL and testbench
================================

// Module: uart_frame_rx
// PURPOSE
//  Downstream consumer of the UART receiver: takes the byte stream (rx_out / rx_done_tick) and
//  deframes fixed 5-byte game-command frames [SOF, CMD, X, Y, CHK], with CHK = CMD^X^Y.
//  Delivers validated CMD/X/Y to the game logic with a 1-cycle valid strobe.
//  Discards malformed or stalled frames and resynchronises on the next SOF.
// PARAMETERS
//  SOF_BYTE        8'hA5    start-of-frame marker byte
//  TIMEOUT_CYCLES  100000   max clk cycles between bytes inside a frame (1 ms @ 100 MHz)
// PORTS
//  clk           in   1   system clock, single clock domain
//  rst           in   1   asynchronous, active-low reset
//  rx_byte       in   8   received byte, valid only when rx_done_tick=1
//  rx_done_tick  in   1   1-cycle strobe from UART receiver, one per byte
//  frame_valid   out  1   1-cycle strobe: new good frame on cmd/x/y
//  cmd           out  8   command field of last good frame
//  x             out  8   X field of last good frame
//  y             out  8   Y field of last good frame
//  chk_err       out  1   1-cycle strobe: checksum mismatch, frame dropped
//  timeout_err   out  1   1-cycle strobe: inter-byte timeout, frame dropped
//  frame_cnt     out  16  good-frame count (FRAME_STATS_EN only, else 0)
//  err_cnt       out  16  chk_err+timeout_err count (FRAME_STATS_EN only, else 0)
// BEHAVIOUR
//  - Reset (rst=0, async): state=IDLE, timer=0, all outputs 0.
//  - FSM states IDLE -> GET_CMD -> GET_X -> GET_Y -> GET_CHK -> IDLE; advance only on rx_done_tick.
//  - IDLE: tick with rx_byte==SOF_BYTE -> GET_CMD; any other byte ignored, stay IDLE.
//  - GET_CMD/X/Y: tick captures byte into shadow reg, next state. SOF_BYTE inside payload is data.
//  - GET_CHK: tick compares rx_byte with cmd_s^x_s^y_s; -> IDLE in either case.
//    match: cmd/x/y <= shadow regs and frame_valid=1 in the cycle after the CHK tick.
//    mismatch: chk_err=1 in cycle after CHK tick; cmd/x/y unchanged.
//  - cmd/x/y change only on a good frame; hold value otherwise (incl. across errors).
//  - Timer: cleared on every tick and in IDLE; increments each cycle in non-IDLE states.
//    Reaching TIMEOUT_CYCLES-1 with no tick -> IDLE, timeout_err=1 next cycle, shadow discarded.
//  - Tick and timeout in same cycle: tick wins, timer clears, no timeout_err.
//  - Strobes are registered, exactly 1 cycle wide, mutually exclusive.
//  - Back-to-back frames: SOF tick may arrive the cycle after the CHK tick; no dead cycle required.
//  - Reset mid-frame: partial frame lost, no strobes emitted.
// CONFIGURATION
//  Macro FRAME_STATS_EN:
//   defined:   frame_cnt +1 per frame_valid, err_cnt +1 per chk_err/timeout_err; both saturate
//              at 16'hFFFF; reset to 0.
//   undefined: counters not built; frame_cnt/err_cnt tied to 16'h0000. Ports exist in both builds.
// STRUCTURE
//  - Package uart_frame_pkg: frame_state_t enum (IDLE, GET_CMD, GET_X, GET_Y, GET_CHK),
//    game_cmd_t struct {cmd,x,y}, default SOF constant 8'hA5, FRAME_LEN=5.
//  - Sub-module uart_frame_timeout: timer with clear/enable/expire, parameter TIMEOUT_CYCLES.
//  - Top: FSM, shadow regs, checksum compare, output regs, optional stats counters.
// TESTING
//  1 Good frame A5,01,10,20,31 -> frame_valid 1 cycle after CHK tick; cmd=01 x=10 y=20.
//  2 Bad checksum A5,01,10,20,00 -> chk_err pulse, no frame_valid, cmd/x/y keep prior values.
//  3 Garbage 00,FF,5A then good frame A5,02,03,04,05 -> only one frame_valid, cmd=02 x=03 y=04.
//  4 A5,07 then idle > TIMEOUT_CYCLES (TIMEOUT_CYCLES=50 in bench) -> timeout_err once, state IDLE;
//    following good frame accepted.
//  5 Tick on exact expiry cycle -> no timeout_err, frame continues; also rst low mid-frame ->
//    all outputs 0 immediately, no strobe after release.
//  6 FRAME_STATS_EN build: 3 good + 2 bad frames -> frame_cnt=3, err_cnt=2; non-stats build ->
//    both read 0.

Source files
------------

// File: rtl/uart_frame_pkg.sv
// Shared types and constants for the UART game-command frame receiver.
// Frame layout on the wire: [SOF, CMD, X, Y, CHK] with CHK = CMD ^ X ^ Y.
package uart_frame_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        GET_CMD = 3'd1,
        GET_X   = 3'd2,
        GET_Y   = 3'd3,
        GET_CHK = 3'd4
    } frame_state_t;

    typedef struct packed {
        logic [7:0] cmd;
        logic [7:0] x;
        logic [7:0] y;
    } game_cmd_t;

    localparam logic [7:0] SOF_DEFAULT = 8'hA5;
    localparam int         FRAME_LEN   = 5;

    // Expected check byte for a captured payload.
    function automatic logic [7:0] calc_chk(input game_cmd_t c);
        calc_chk = c.cmd ^ c.x ^ c.y;
    endfunction

endpackage

// File: rtl/uart_frame_timeout.sv
// Inter-byte watchdog for the frame receiver.
// Counts cycles while enabled; clear has priority over expiry so a byte
// arriving on the last permitted cycle keeps the frame alive.
module uart_frame_timeout #(
    parameter int TIMEOUT_CYCLES = 100000
) (
    input  logic clk,
    input  logic rst,
    input  logic clear_i,
    input  logic enable_i,
    output logic expire_o
);

    localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TW-1:0] LIMIT = TW'(TIMEOUT_CYCLES - 1);

    logic [TW-1:0] timer_q;
    logic [TW-1:0] timer_d;
    logic          expire_s;

    // Expiry detection and next timer value.
    always_comb begin
        expire_s = 1'b0;
        timer_d  = timer_q;
        if (clear_i) begin
            timer_d = {TW{1'b0}};
        end else if (enable_i) begin
            if (timer_q == LIMIT) begin
                expire_s = 1'b1;
                timer_d  = {TW{1'b0}};
            end else begin
                timer_d = timer_q + {{(TW-1){1'b0}}, 1'b1};
            end
        end else begin
            timer_d = {TW{1'b0}};
        end
    end

    // Timer register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            timer_q <= {TW{1'b0}};
        end else begin
            timer_q <= timer_d;
        end
    end

    assign expire_o = expire_s;

endmodule

// File: rtl/uart_frame_rx.sv
// Deframes 5-byte game-command frames from a UART byte stream and delivers
// validated CMD/X/Y with a one-cycle strobe. Malformed or stalled frames are
// dropped and the receiver resynchronises on the next SOF byte.
// Optional build macro: FRAME_STATS_EN adds saturating good/error frame counters;
// without it frame_cnt/err_cnt read as zero.
module uart_frame_rx
    import uart_frame_pkg::*;
#(
    parameter logic [7:0] SOF_BYTE       = SOF_DEFAULT,
    parameter int         TIMEOUT_CYCLES = 100000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  rx_byte,
    input  logic        rx_done_tick,
    output logic        frame_valid,
    output logic [7:0]  cmd,
    output logic [7:0]  x,
    output logic [7:0]  y,
    output logic        chk_err,
    output logic        timeout_err,
    output logic [15:0] frame_cnt,
    output logic [15:0] err_cnt
);

    frame_state_t state_q, state_d;
    game_cmd_t    shadow_q, shadow_d;
    game_cmd_t    out_q, out_d;
    logic         frame_valid_q, frame_valid_d;
    logic         chk_err_q, chk_err_d;
    logic         timeout_err_q, timeout_err_d;

    logic         tmr_clear_s;
    logic         tmr_enable_s;
    logic         tmr_expire_s;

    // Timer runs only inside a frame and restarts on every received byte.
    always_comb begin
        tmr_enable_s = (state_q != IDLE);
        tmr_clear_s  = rx_done_tick | (state_q == IDLE);
    end

    uart_frame_timeout #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_timeout (
        .clk      (clk),
        .rst      (rst),
        .clear_i  (tmr_clear_s),
        .enable_i (tmr_enable_s),
        .expire_o (tmr_expire_s)
    );

    // Frame FSM: byte capture, checksum decision and strobe generation.
    always_comb begin
        state_d       = state_q;
        shadow_d      = shadow_q;
        out_d         = out_q;
        frame_valid_d = 1'b0;
        chk_err_d     = 1'b0;
        timeout_err_d = 1'b0;

        case (state_q)
            IDLE: begin
                if (rx_done_tick && (rx_byte == SOF_BYTE)) begin
                    state_d = GET_CMD;
                end else begin
                    state_d = IDLE;
                end
            end
            GET_CMD: begin
                if (rx_done_tick) begin
                    shadow_d.cmd = rx_byte;
                    state_d      = GET_X;
                end else if (tmr_expire_s) begin
                    shadow_d      = '0;
                    timeout_err_d = 1'b1;
                    state_d       = IDLE;
                end else begin
                    state_d = GET_CMD;
                end
            end
            GET_X: begin
                if (rx_done_tick) begin
                    shadow_d.x = rx_byte;
                    state_d    = GET_Y;
                end else if (tmr_expire_s) begin
                    shadow_d      = '0;
                    timeout_err_d = 1'b1;
                    state_d       = IDLE;
                end else begin
                    state_d = GET_X;
                end
            end
            GET_Y: begin
                if (rx_done_tick) begin
                    shadow_d.y = rx_byte;
                    state_d    = GET_CHK;
                end else if (tmr_expire_s) begin
                    shadow_d      = '0;
                    timeout_err_d = 1'b1;
                    state_d       = IDLE;
                end else begin
                    state_d = GET_Y;
                end
            end
            GET_CHK: begin
                if (rx_done_tick) begin
                    if (rx_byte == calc_chk(shadow_q)) begin
                        out_d         = shadow_q;
                        frame_valid_d = 1'b1;
                    end else begin
                        chk_err_d = 1'b1;
                    end
                    state_d = IDLE;
                end else if (tmr_expire_s) begin
                    shadow_d      = '0;
                    timeout_err_d = 1'b1;
                    state_d       = IDLE;
                end else begin
                    state_d = GET_CHK;
                end
            end
            default: begin
                shadow_d = '0;
                state_d  = IDLE;
            end
        endcase
    end

    // State, shadow payload and registered outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= IDLE;
            shadow_q      <= '0;
            out_q         <= '0;
            frame_valid_q <= 1'b0;
            chk_err_q     <= 1'b0;
            timeout_err_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            shadow_q      <= shadow_d;
            out_q         <= out_d;
            frame_valid_q <= frame_valid_d;
            chk_err_q     <= chk_err_d;
            timeout_err_q <= timeout_err_d;
        end
    end

`ifdef FRAME_STATS_EN
    logic [15:0] frame_cnt_q, frame_cnt_d;
    logic [15:0] err_cnt_q, err_cnt_d;

    // Saturating statistics, updated together with the strobe registers.
    always_comb begin
        frame_cnt_d = frame_cnt_q;
        err_cnt_d   = err_cnt_q;
        if (frame_valid_d && (frame_cnt_q != 16'hFFFF)) begin
            frame_cnt_d = frame_cnt_q + 16'd1;
        end else begin
            frame_cnt_d = frame_cnt_q;
        end
        if ((chk_err_d || timeout_err_d) && (err_cnt_q != 16'hFFFF)) begin
            err_cnt_d = err_cnt_q + 16'd1;
        end else begin
            err_cnt_d = err_cnt_q;
        end
    end

    // Statistics registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            frame_cnt_q <= 16'h0000;
            err_cnt_q   <= 16'h0000;
        end else begin
            frame_cnt_q <= frame_cnt_d;
            err_cnt_q   <= err_cnt_d;
        end
    end

    assign frame_cnt = frame_cnt_q;
    assign err_cnt   = err_cnt_q;
`else
    assign frame_cnt = 16'h0000;
    assign err_cnt   = 16'h0000;
`endif

    assign frame_valid = frame_valid_q;
    assign chk_err     = chk_err_q;
    assign timeout_err = timeout_err_q;
    assign cmd         = out_q.cmd;
    assign x           = out_q.x;
    assign y           = out_q.y;

endmodule

// File: tb/tb_uart_frame_rx.sv
// Directed self-checking bench for uart_frame_rx (TIMEOUT_CYCLES = 50).
module tb_uart_frame_rx;

    logic        clk;
    logic        rst;
    logic [7:0]  rx_byte;
    logic        rx_done_tick;
    logic        frame_valid;
    logic [7:0]  cmd;
    logic [7:0]  x;
    logic [7:0]  y;
    logic        chk_err;
    logic        timeout_err;
    logic [15:0] frame_cnt;
    logic [15:0] err_cnt;

    int checks   = 0;
    int failures = 0;
    int fv_seen  = 0;
    int ce_seen  = 0;
    int te_seen  = 0;
    int fv_base;
    int ce_base;
    int te_base;

    uart_frame_rx #(
        .SOF_BYTE       (8'hA5),
        .TIMEOUT_CYCLES (50)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .rx_byte      (rx_byte),
        .rx_done_tick (rx_done_tick),
        .frame_valid  (frame_valid),
        .cmd          (cmd),
        .x            (x),
        .y            (y),
        .chk_err      (chk_err),
        .timeout_err  (timeout_err),
        .frame_cnt    (frame_cnt),
        .err_cnt      (err_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Strobe pulse counters sampled mid-cycle.
    always @(negedge clk) begin
        if (frame_valid) fv_seen++;
        if (chk_err)     ce_seen++;
        if (timeout_err) te_seen++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Called at posedge+1; leaves the caller at the posedge+1 after the tick edge.
    task automatic send_byte(input logic [7:0] b);
        rx_byte      = b;
        rx_done_tick = 1'b1;
        @(posedge clk); #1;
        rx_done_tick = 1'b0;
        rx_byte      = 8'h00;
    endtask

    task automatic send_frame(input logic [7:0] c, input logic [7:0] xx,
                              input logic [7:0] yy, input logic [7:0] k);
        send_byte(8'hA5);
        send_byte(c);
        send_byte(xx);
        send_byte(yy);
        send_byte(k);
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic mark();
        fv_base = fv_seen;
        ce_base = ce_seen;
        te_base = te_seen;
    endtask

    initial begin
        rst          = 1'b0;
        rx_byte      = 8'h00;
        rx_done_tick = 1'b0;
        idle(3);
        check("reset_fv",  {31'd0, frame_valid}, 32'd0);
        check("reset_ce",  {31'd0, chk_err},     32'd0);
        check("reset_te",  {31'd0, timeout_err}, 32'd0);
        check("reset_cmd", {8'd0, cmd, x, y},    32'd0);
        check("reset_cnt", {frame_cnt, err_cnt}, 32'd0);
        rst = 1'b1;
        idle(2);

        // 1: good frame, strobe in the cycle after CHK tick
        send_frame(8'h01, 8'h10, 8'h20, 8'h31);
        check("t1_fv_now",  {31'd0, frame_valid}, 32'd1);
        check("t1_cmdxy",   {8'd0, cmd, x, y},    32'h0001_1020);
        idle(1);
        check("t1_fv_drop", {31'd0, frame_valid}, 32'd0);

        // 2: bad checksum
        mark();
        send_frame(8'h01, 8'h10, 8'h20, 8'h00);
        check("t2_ce_now", {31'd0, chk_err},     32'd1);
        check("t2_fv_now", {31'd0, frame_valid}, 32'd0);
        idle(2);
        check("t2_hold",   {8'd0, cmd, x, y},    32'h0001_1020);
        check("t2_ce_cnt", ce_seen - ce_base,    32'd1);
        check("t2_fv_cnt", fv_seen - fv_base,    32'd0);

        // 3: garbage before a good frame
        mark();
        send_byte(8'h00);
        send_byte(8'hFF);
        send_byte(8'h5A);
        send_frame(8'h02, 8'h03, 8'h04, 8'h05);
        idle(2);
        check("t3_fv_cnt", fv_seen - fv_base, 32'd1);
        check("t3_cmdxy",  {8'd0, cmd, x, y}, 32'h0002_0304);

        // 4: stall after CMD triggers timeout after 50 cycles
        mark();
        send_byte(8'hA5);
        send_byte(8'h07);
        idle(49);
        check("t4_te_early", {31'd0, timeout_err}, 32'd0);
        idle(1);
        check("t4_te_now",   {31'd0, timeout_err}, 32'd1);
        idle(1);
        check("t4_te_drop",  {31'd0, timeout_err}, 32'd0);
        idle(3);
        check("t4_te_cnt",   te_seen - te_base,    32'd1);
        send_frame(8'h0A, 8'h0B, 8'h0C, 8'h0D);
        idle(1);
        check("t4_after",    {8'd0, cmd, x, y},    32'h000A_0B0C);

        // 5a: tick exactly on expiry cycle wins
        mark();
        send_byte(8'hA5);
        send_byte(8'h07);
        idle(49);
        send_byte(8'h10);
        send_byte(8'h20);
        send_byte(8'h37);
        idle(2);
        check("t5_no_te",  te_seen - te_base,  32'd0);
        check("t5_fv_cnt", fv_seen - fv_base,  32'd1);
        check("t5_cmdxy",  {8'd0, cmd, x, y},  32'h0007_1020);

        // SOF inside payload is data; back-to-back frames with no gap
        mark();
        send_frame(8'hA5, 8'hA5, 8'hA5, 8'hA5);
        check("sof_payload", {8'd0, cmd, x, y}, 32'h00A5_A5A5);
        send_frame(8'h11, 8'h22, 8'h33, 8'h00);
        send_frame(8'h01, 8'h02, 8'h04, 8'h07);
        idle(2);
        check("b2b_fv_cnt", fv_seen - fv_base, 32'd3);
        check("b2b_cmdxy",  {8'd0, cmd, x, y}, 32'h0001_0204);

        // 5b: reset mid-frame
        mark();
        send_byte(8'hA5);
        send_byte(8'h01);
        rst = 1'b0;
        #1;
        check("rst_mid_cmd", {8'd0, cmd, x, y}, 32'd0);
        check("rst_mid_str", {29'd0, frame_valid, chk_err, timeout_err}, 32'd0);
        idle(2);
        rst = 1'b1;
        idle(1);
        send_byte(8'h10);
        send_byte(8'h20);
        send_byte(8'h31);
        idle(60);
        check("rst_no_str", (fv_seen - fv_base) + (ce_seen - ce_base) + (te_seen - te_base), 32'd0);

        // 6: statistics, 3 good + 2 bad after a fresh reset
        rst = 1'b0;
        idle(2);
        rst = 1'b1;
        idle(1);
        send_frame(8'h01, 8'h10, 8'h20, 8'h31);
        send_frame(8'h01, 8'h10, 8'h20, 8'h00);
        send_frame(8'h02, 8'h03, 8'h04, 8'h05);
        send_byte(8'hA5);
        idle(55);
        send_frame(8'h11, 8'h22, 8'h33, 8'h00);
        idle(2);
`ifdef FRAME_STATS_EN
        check("stats_frame", {16'd0, frame_cnt}, 32'd3);
        check("stats_err",   {16'd0, err_cnt},   32'd2);
`else
        check("stats_frame", {16'd0, frame_cnt}, 32'd0);
        check("stats_err",   {16'd0, err_cnt},   32'd0);
`endif
        check("stats_cmdxy", {8'd0, cmd, x, y}, 32'h0011_2233);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
